// File: rtl/y86_decode_stage.sv
// Y86-64 decode slice: D pipeline register, register-ID generation, operand
// forwarding/selection and the E pipeline register feeding execute.
module y86_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    input  logic        E_bubble_i,
    input  logic [3:0]  f_icode_i,
    input  logic [3:0]  f_ifun_i,
    input  logic [3:0]  f_rA_i,
    input  logic [3:0]  f_rB_i,
    input  logic [63:0] f_valC_i,
    input  logic [63:0] f_valP_i,
    input  logic [2:0]  f_stat_i,
    input  logic [63:0] d_rvalA_i,
    input  logic [63:0] d_rvalB_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [3:0]  W_dstE_i,
    input  logic [3:0]  W_dstM_i,
    input  logic [63:0] e_valE_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] m_valM_i,
    input  logic [63:0] W_valE_i,
    input  logic [63:0] W_valM_i,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  d_srcA_o,
    output logic [3:0]  d_srcB_o,
    output logic [3:0]  d_dstE_o,
    output logic [3:0]  d_dstM_o,
    output logic [63:0] d_valA_o,
    output logic [63:0] d_valB_o,
    output logic [2:0]  E_stat_o,
    output logic [3:0]  E_icode_o,
    output logic [3:0]  E_ifun_o,
    output logic [63:0] E_valC_o,
    output logic [63:0] E_valA_o,
    output logic [63:0] E_valB_o,
    output logic [3:0]  E_dstE_o,
    output logic [3:0]  E_dstM_o,
    output logic [3:0]  E_srcA_o,
    output logic [3:0]  E_srcB_o
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [2:0] SAOK  = 3'b001;

    // D register: stall holds and takes precedence over bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_icode_o <= NOP;
            D_ifun_o  <= 4'h0;
            D_rA_o    <= RNONE;
            D_rB_o    <= RNONE;
            D_valC_o  <= 64'h0;
            D_valP_o  <= 64'h0;
            D_stat_o  <= SAOK;
        end else if (D_stall_i) begin
            D_icode_o <= D_icode_o;
        end else if (D_bubble_i) begin
            D_icode_o <= NOP;
            D_ifun_o  <= 4'h0;
            D_rA_o    <= RNONE;
            D_rB_o    <= RNONE;
            D_valC_o  <= 64'h0;
            D_valP_o  <= 64'h0;
            D_stat_o  <= SAOK;
        end else begin
            D_icode_o <= f_icode_i;
            D_ifun_o  <= f_ifun_i;
            D_rA_o    <= f_rA_i;
            D_rB_o    <= f_rB_i;
            D_valC_o  <= f_valC_i;
            D_valP_o  <= f_valP_i;
            D_stat_o  <= f_stat_i;
        end
    end

    always_comb begin
        d_srcA_o = RNONE;
        d_srcB_o = RNONE;
        d_dstE_o = RNONE;
        d_dstM_o = RNONE;
        case (D_icode_o)
            4'h2, 4'h4, 4'h6, 4'hA: d_srcA_o = D_rA_o;
            4'h9, 4'hB:             d_srcA_o = RRSP;
            default:                d_srcA_o = RNONE;
        endcase
        case (D_icode_o)
            4'h4, 4'h5, 4'h6:       d_srcB_o = D_rB_o;
            4'h8, 4'h9, 4'hA, 4'hB: d_srcB_o = RRSP;
            default:                d_srcB_o = RNONE;
        endcase
        // cmov is written unconditionally here; execute squashes it on a false condition
        case (D_icode_o)
            4'h2, 4'h3, 4'h6:       d_dstE_o = D_rB_o;
            4'h8, 4'h9, 4'hA, 4'hB: d_dstE_o = RRSP;
            default:                d_dstE_o = RNONE;
        endcase
        case (D_icode_o)
            4'h5, 4'hB: d_dstM_o = D_rA_o;
            default:    d_dstM_o = RNONE;
        endcase
    end

    // Youngest producer wins; RNONE never forwards so raw regfile data passes through
    always_comb begin
        d_valA_o = d_rvalA_i;
        if (D_icode_o == 4'h7 || D_icode_o == 4'h8)            d_valA_o = D_valP_o;
        else if (d_srcA_o == RNONE)                            d_valA_o = d_rvalA_i;
        else if (d_srcA_o == e_dstE_i)                         d_valA_o = e_valE_i;
        else if (d_srcA_o == M_dstM_i)                         d_valA_o = m_valM_i;
        else if (d_srcA_o == M_dstE_i)                         d_valA_o = M_valE_i;
        else if (d_srcA_o == W_dstM_i)                         d_valA_o = W_valM_i;
        else if (d_srcA_o == W_dstE_i)                         d_valA_o = W_valE_i;
    end

    always_comb begin
        d_valB_o = d_rvalB_i;
        if (d_srcB_o == RNONE)         d_valB_o = d_rvalB_i;
        else if (d_srcB_o == e_dstE_i) d_valB_o = e_valE_i;
        else if (d_srcB_o == M_dstM_i) d_valB_o = m_valM_i;
        else if (d_srcB_o == M_dstE_i) d_valB_o = M_valE_i;
        else if (d_srcB_o == W_dstM_i) d_valB_o = W_valM_i;
        else if (d_srcB_o == W_dstE_i) d_valB_o = W_valE_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || E_bubble_i) begin
            E_stat_o  <= SAOK;
            E_icode_o <= NOP;
            E_ifun_o  <= 4'h0;
            E_valC_o  <= 64'h0;
            E_valA_o  <= 64'h0;
            E_valB_o  <= 64'h0;
            E_dstE_o  <= RNONE;
            E_dstM_o  <= RNONE;
            E_srcA_o  <= RNONE;
            E_srcB_o  <= RNONE;
        end else begin
            E_stat_o  <= D_stat_o;
            E_icode_o <= D_icode_o;
            E_ifun_o  <= D_ifun_o;
            E_valC_o  <= D_valC_o;
            E_valA_o  <= d_valA_o;
            E_valB_o  <= d_valB_o;
            E_dstE_o  <= d_dstE_o;
            E_dstM_o  <= d_dstM_o;
            E_srcA_o  <= d_srcA_o;
            E_srcB_o  <= d_srcB_o;
        end
    end

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed bench for y86_decode_stage: the driver queues expected values, a
// negedge monitor pops them and compares against the live DUT outputs.
module tb_y86_decode_stage;

    logic        clk, rst;
    logic        D_stall_i, D_bubble_i, E_bubble_i;
    logic [3:0]  f_icode_i, f_ifun_i, f_rA_i, f_rB_i;
    logic [63:0] f_valC_i, f_valP_i;
    logic [2:0]  f_stat_i;
    logic [63:0] d_rvalA_i, d_rvalB_i;
    logic [3:0]  e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i;
    logic [63:0] e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i;
    logic [3:0]  D_icode_o, D_ifun_o, D_rA_o, D_rB_o;
    logic [63:0] D_valC_o, D_valP_o;
    logic [2:0]  D_stat_o;
    logic [3:0]  d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o;
    logic [63:0] d_valA_o, d_valB_o;
    logic [2:0]  E_stat_o;
    logic [3:0]  E_icode_o, E_ifun_o;
    logic [63:0] E_valC_o, E_valA_o, E_valB_o;
    logic [3:0]  E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;

    y86_decode_stage dut (
        .clk(clk), .rst(rst),
        .D_stall_i(D_stall_i), .D_bubble_i(D_bubble_i), .E_bubble_i(E_bubble_i),
        .f_icode_i(f_icode_i), .f_ifun_i(f_ifun_i), .f_rA_i(f_rA_i), .f_rB_i(f_rB_i),
        .f_valC_i(f_valC_i), .f_valP_i(f_valP_i), .f_stat_i(f_stat_i),
        .d_rvalA_i(d_rvalA_i), .d_rvalB_i(d_rvalB_i),
        .e_dstE_i(e_dstE_i), .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i),
        .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i),
        .e_valE_i(e_valE_i), .M_valE_i(M_valE_i), .m_valM_i(m_valM_i),
        .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
        .D_icode_o(D_icode_o), .D_ifun_o(D_ifun_o), .D_rA_o(D_rA_o), .D_rB_o(D_rB_o),
        .D_valC_o(D_valC_o), .D_valP_o(D_valP_o), .D_stat_o(D_stat_o),
        .d_srcA_o(d_srcA_o), .d_srcB_o(d_srcB_o), .d_dstE_o(d_dstE_o), .d_dstM_o(d_dstM_o),
        .d_valA_o(d_valA_o), .d_valB_o(d_valB_o),
        .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
        .E_valC_o(E_valC_o), .E_valA_o(E_valA_o), .E_valB_o(E_valB_o),
        .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_D_ICODE = 0,  S_D_RA   = 1,  S_D_RB   = 2,  S_D_VALC = 3;
    localparam int S_D_VALP  = 4,  S_D_STAT = 5,  S_SRCA   = 6,  S_SRCB   = 7;
    localparam int S_DSTE    = 8,  S_DSTM   = 9,  S_VALA   = 10, S_VALB   = 11;
    localparam int S_E_ICODE = 12, S_E_VALC = 13, S_E_VALA = 14, S_E_VALB = 15;
    localparam int S_E_DSTE  = 16, S_E_DSTM = 17, S_E_SRCA = 18, S_E_STAT = 19;

    logic [63:0] exp_q[$];
    int          sig_q[$];
    int          checks = 0;
    int          passed = 0;
    bit          done   = 1'b0;

    function automatic string sig_name(input int s);
        case (s)
            S_D_ICODE: return "D_icode";  S_D_RA:   return "D_rA";
            S_D_RB:    return "D_rB";     S_D_VALC: return "D_valC";
            S_D_VALP:  return "D_valP";   S_D_STAT: return "D_stat";
            S_SRCA:    return "d_srcA";   S_SRCB:   return "d_srcB";
            S_DSTE:    return "d_dstE";   S_DSTM:   return "d_dstM";
            S_VALA:    return "d_valA";   S_VALB:   return "d_valB";
            S_E_ICODE: return "E_icode";  S_E_VALC: return "E_valC";
            S_E_VALA:  return "E_valA";   S_E_VALB: return "E_valB";
            S_E_DSTE:  return "E_dstE";   S_E_DSTM: return "E_dstM";
            S_E_SRCA:  return "E_srcA";   S_E_STAT: return "E_stat";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [63:0] get_sig(input int s);
        case (s)
            S_D_ICODE: return {60'h0, D_icode_o};  S_D_RA:   return {60'h0, D_rA_o};
            S_D_RB:    return {60'h0, D_rB_o};     S_D_VALC: return D_valC_o;
            S_D_VALP:  return D_valP_o;            S_D_STAT: return {61'h0, D_stat_o};
            S_SRCA:    return {60'h0, d_srcA_o};   S_SRCB:   return {60'h0, d_srcB_o};
            S_DSTE:    return {60'h0, d_dstE_o};   S_DSTM:   return {60'h0, d_dstM_o};
            S_VALA:    return d_valA_o;            S_VALB:   return d_valB_o;
            S_E_ICODE: return {60'h0, E_icode_o};  S_E_VALC: return E_valC_o;
            S_E_VALA:  return E_valA_o;            S_E_VALB: return E_valB_o;
            S_E_DSTE:  return {60'h0, E_dstE_o};   S_E_DSTM: return {60'h0, E_dstM_o};
            S_E_SRCA:  return {60'h0, E_srcA_o};   S_E_STAT: return {61'h0, E_stat_o};
            default:   return 64'hDEAD;
        endcase
    endfunction

    // driver tasks
    task automatic expect_sig(input int s, input logic [63:0] v);
        sig_q.push_back(s);
        exp_q.push_back(v);
    endtask

    task automatic check_now(input int s, input logic [63:0] e);
        logic [63:0] a;
        a = get_sig(s);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s (immediate): got 0x%0h expected 0x%0h at %0t", sig_name(s), a, e, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valc, input logic [63:0] valp);
        f_icode_i = icode; f_ifun_i = 4'h0; f_rA_i = ra; f_rB_i = rb;
        f_valC_i = valc; f_valP_i = valp; f_stat_i = 3'b001;
    endtask

    // scoreboard monitor: drains everything queued for this half-cycle
    initial begin
        while (!done) begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                automatic int          s = sig_q.pop_front();
                automatic logic [63:0] e = exp_q.pop_front();
                automatic logic [63:0] a = get_sig(s);
                checks++;
                if (a === e) passed++;
                else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", sig_name(s), a, e, $time);
            end
        end
    end

    initial begin
        rst = 1'b1;
        D_stall_i = 1'b0; D_bubble_i = 1'b0; E_bubble_i = 1'b0;
        fetch(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        d_rvalA_i = 64'h0; d_rvalB_i = 64'h0;
        e_dstE_i = 4'hF; M_dstE_i = 4'hF; M_dstM_i = 4'hF; W_dstE_i = 4'hF; W_dstM_i = 4'hF;
        e_valE_i = 64'h0; M_valE_i = 64'h0; m_valM_i = 64'h0; W_valE_i = 64'h0; W_valM_i = 64'h0;
        #1;
        check_now(S_D_ICODE, 64'h1);
        check_now(S_D_RA, 64'hF);
        check_now(S_E_ICODE, 64'h1);
        check_now(S_E_DSTE, 64'hF);
        step();
        step();
        rst = 1'b0;
        expect_sig(S_D_ICODE, 64'h1);
        expect_sig(S_E_DSTE, 64'hF);

        // irmovq $2, %rbp
        fetch(4'h3, 4'hF, 4'h5, 64'h2, 64'hA);
        step();
        expect_sig(S_D_ICODE, 64'h3);
        expect_sig(S_DSTE, 64'h5);
        expect_sig(S_SRCA, 64'hF);
        expect_sig(S_SRCB, 64'hF);
        expect_sig(S_DSTM, 64'hF);
        // OPq %rbp, %rsi with no forwarding
        fetch(4'h6, 4'h5, 4'h6, 64'h0, 64'hC);
        d_rvalA_i = 64'h11; d_rvalB_i = 64'h22;
        step();
        expect_sig(S_E_ICODE, 64'h3);
        expect_sig(S_E_DSTE, 64'h5);
        expect_sig(S_E_VALC, 64'h2);
        expect_sig(S_SRCA, 64'h5);
        expect_sig(S_SRCB, 64'h6);
        expect_sig(S_DSTE, 64'h6);
        expect_sig(S_VALA, 64'h11);
        expect_sig(S_VALB, 64'h22);
        // stall together with bubble: stall wins, call waits in fetch
        fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h40);
        D_stall_i = 1'b1; D_bubble_i = 1'b1;
        step();
        expect_sig(S_D_ICODE, 64'h6);
        expect_sig(S_D_RA, 64'h5);
        expect_sig(S_D_VALP, 64'hC);
        expect_sig(S_E_ICODE, 64'h6);
        expect_sig(S_E_VALA, 64'h11);
        expect_sig(S_E_VALB, 64'h22);
        // e beats W on srcA; M_dstM beats M_dstE on srcB
        e_dstE_i = 4'h5; e_valE_i = 64'hAA;
        W_dstE_i = 4'h5; W_valE_i = 64'hBB;
        M_dstM_i = 4'h6; m_valM_i = 64'hCC;
        M_dstE_i = 4'h6; M_valE_i = 64'hDD;
        expect_sig(S_VALA, 64'hAA);
        expect_sig(S_VALB, 64'hCC);
        D_stall_i = 1'b0; D_bubble_i = 1'b0;
        step();
        // call: valA is valP, rsp is both source B and destination E
        expect_sig(S_E_VALA, 64'hAA);
        expect_sig(S_E_VALB, 64'hCC);
        expect_sig(S_D_ICODE, 64'h8);
        expect_sig(S_VALA, 64'h40);
        expect_sig(S_SRCA, 64'hF);
        expect_sig(S_SRCB, 64'h4);
        expect_sig(S_DSTE, 64'h4);
        expect_sig(S_DSTM, 64'hF);
        expect_sig(S_VALB, 64'h22);
        fetch(4'h2, 4'h1, 4'h2, 64'h0, 64'h50);
        D_bubble_i = 1'b1;
        step();
        // D bubbled to NOP while E takes the call
        expect_sig(S_D_ICODE, 64'h1);
        expect_sig(S_D_RA, 64'hF);
        expect_sig(S_D_VALP, 64'h0);
        expect_sig(S_E_ICODE, 64'h8);
        expect_sig(S_E_VALA, 64'h40);
        expect_sig(S_E_DSTE, 64'h4);
        W_dstM_i = 4'hF; W_valM_i = 64'hEE;
        expect_sig(S_VALA, 64'h11);
        expect_sig(S_VALB, 64'h22);
        D_bubble_i = 1'b0;
        E_bubble_i = 1'b1;
        fetch(4'hB, 4'h3, 4'hF, 64'h0, 64'h52);
        step();
        // popq %rbx; W_dstM beats W_dstE
        expect_sig(S_E_ICODE, 64'h1);
        expect_sig(S_E_DSTE, 64'hF);
        expect_sig(S_E_VALA, 64'h0);
        expect_sig(S_SRCA, 64'h4);
        expect_sig(S_SRCB, 64'h4);
        expect_sig(S_DSTE, 64'h4);
        expect_sig(S_DSTM, 64'h3);
        W_dstM_i = 4'h4; W_valM_i = 64'h77;
        W_dstE_i = 4'h4; W_valE_i = 64'h66;
        expect_sig(S_VALA, 64'h77);
        expect_sig(S_VALB, 64'h77);
        E_bubble_i = 1'b0;
        step();
        expect_sig(S_E_ICODE, 64'hB);
        expect_sig(S_E_SRCA, 64'h4);
        expect_sig(S_E_DSTM, 64'h3);
        expect_sig(S_E_VALA, 64'h77);
        step();
        // asynchronous reset mid-run, checked before any rising edge
        rst = 1'b1;
        #1;
        check_now(S_D_ICODE, 64'h1);
        check_now(S_D_RB, 64'hF);
        check_now(S_D_VALP, 64'h0);
        check_now(S_E_ICODE, 64'h1);
        check_now(S_E_DSTM, 64'hF);
        check_now(S_E_VALA, 64'h0);
        expect_sig(S_D_ICODE, 64'h1);
        expect_sig(S_D_RA, 64'hF);
        expect_sig(S_D_RB, 64'hF);
        expect_sig(S_D_VALC, 64'h0);
        expect_sig(S_D_VALP, 64'h0);
        expect_sig(S_D_STAT, 64'h1);
        expect_sig(S_E_ICODE, 64'h1);
        expect_sig(S_E_VALA, 64'h0);
        expect_sig(S_E_DSTE, 64'hF);
        expect_sig(S_E_DSTM, 64'hF);
        expect_sig(S_E_SRCA, 64'hF);
        expect_sig(S_E_STAT, 64'h1);
        step();
        rst = 1'b0;
        step();
        done = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard: %0d expected values never checked", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
